// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encoding and frame constants for the program loader
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hB0;

endpackage

// File: rtl/loader_word_packer.sv
// rtl/loader_word_packer.sv - little-endian byte-to-word assembler with running XOR checksum
module loader_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic [7:0]  o_csum,
    output logic        o_word_ready
);

    logic [1:0]  r_lane;
    logic [31:0] r_word;
    logic [7:0]  r_csum;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_lane <= 2'd0;
            r_word <= 32'd0;
            r_csum <= 8'd0;
        end else if (i_byte_valid) begin
            r_word[{r_lane, 3'b000} +: 8] <= i_byte;
            r_lane                        <= r_lane + 2'd1;
            r_csum                        <= r_csum ^ i_byte;
        end
    end

    // Fires with the 4th byte, so the full word is in r_word on the next cycle.
    assign o_word_ready = i_byte_valid && (r_lane == 2'd3);
    assign o_word       = r_word;
    assign o_csum       = r_csum;

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed UART image loader writing program memory and holding the CPU in reset
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 11,
    parameter logic [7:0] MAGIC      = DEFAULT_MAGIC,
    parameter int         BASE_WORD  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        start,
    output logic [29:0] mem_address,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [31:0] mem_data_in,
    output logic [3:0]  mem_byte_select,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [ADDR_WIDTH-1:0] LP_BASE  = ADDR_WIDTH'(BASE_WORD);
    localparam logic [31:0]           LP_DEPTH = 32'd1 << ADDR_WIDTH;

    state_t                r_state;
    logic                  r_rx_ready;
    logic                  r_wen;
    logic [3:0]            r_bsel;
    logic                  r_hold;
    logic                  r_done;
    logic                  r_err;
    logic [15:0]           r_len;
    logic [ADDR_WIDTH-1:0] r_widx;

    logic        w_xfer;
    logic        w_start_ok;
    logic [15:0] w_len_next;
    logic        w_too_long;
    logic        w_last_word;
    logic [31:0] w_word;
    logic [7:0]  w_csum;
    logic        w_word_ready;

    assign w_xfer      = rx_valid && r_rx_ready;
    assign w_start_ok  = start && ((r_state == ST_DONE) || (r_state == ST_ERROR));
    assign w_len_next  = {rx_data, r_len[7:0]};
    assign w_too_long  = (32'(w_len_next) + 32'(BASE_WORD)) > LP_DEPTH;
    assign w_last_word = (17'(r_widx) + 17'd1) == 17'(r_len);

    loader_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_start_ok),
        .i_byte_valid (w_xfer && (r_state == ST_DATA)),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_csum       (w_csum),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rx_ready <= 1'b1;
            r_wen      <= 1'b0;
            r_bsel     <= 4'h0;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_len      <= 16'd0;
            r_widx     <= '0;
        end else begin
            r_wen      <= 1'b0;
            r_bsel     <= 4'h0;
            r_rx_ready <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer && (rx_data == MAGIC)) r_state <= ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    if (w_xfer) begin
                        r_len[7:0] <= rx_data;
                        r_state    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_xfer) begin
                        r_len[15:8] <= rx_data;
                        if (w_too_long) begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                        end else if (w_len_next == 16'd0) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_word_ready) begin
                        r_state    <= ST_WRITE;
                        r_wen      <= 1'b1;
                        r_bsel     <= 4'hF;
                        r_rx_ready <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    r_widx  <= r_widx + 1'b1;
                    r_state <= w_last_word ? ST_CSUM : ST_DATA;
                end
                ST_CSUM: begin
                    if (w_xfer) begin
                        if (rx_data == w_csum) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_hold  <= 1'b1;
                        r_len   <= 16'd0;
                        r_widx  <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Memory guards writes against a simultaneous read, so reads stay off.
    assign mem_ren         = 1'b0;
    assign mem_address     = 30'(r_widx + LP_BASE);
    assign mem_wen         = r_wen;
    assign mem_data_in     = w_word;
    assign mem_byte_select = r_bsel;
    assign rx_ready        = r_rx_ready;
    assign cpu_hold        = r_hold;
    assign done            = r_done;
    assign error           = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader against a frame-level model
module tb_prog_loader;

    localparam int         AW   = 11;
    localparam int         BASE = 0;
    localparam logic [7:0] MAG  = 8'hB0;

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        start = 1'b0;
    logic        rx_ready;
    logic [29:0] mem_address;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_byte_select;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int         n_cmp = 0;
    int         n_bad = 0;
    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] frame_q[$];
    bit         exp_done;
    bit         exp_err;
    bit         bp = 1'b0;
    logic       prev_wen = 1'b0;

    prog_loader #(.ADDR_WIDTH(AW), .MAGIC(MAG), .BASE_WORD(BASE)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .rx_ready        (rx_ready),
        .start           (start),
        .mem_address     (mem_address),
        .mem_wen         (mem_wen),
        .mem_ren         (mem_ren),
        .mem_data_in     (mem_data_in),
        .mem_byte_select (mem_byte_select),
        .cpu_hold        (cpu_hold),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("ren_low", 64'(mem_ren), 64'd0);
        chk("ready_only_low_in_write", 64'(rx_ready), 64'(!mem_wen));
        chk("byte_select", 64'(mem_byte_select), mem_wen ? 64'hF : 64'h0);
        chk("wen_single_cycle", 64'(prev_wen && mem_wen), 64'd0);
        if (mem_wen) got_q.push_back({mem_address, mem_data_in});
        prev_wen = mem_wen;
    end

    // Frame-level reference: find MAGIC, read N, pack words little-endian, XOR data bytes.
    function automatic void build_expect();
        int          p = 0;
        int          n;
        logic [7:0]  cs = 8'h00;
        logic [31:0] w;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        while (p < frame_q.size() && frame_q[p] != MAG) p++;
        if (p + 3 > frame_q.size()) return;
        n = int'(frame_q[p+1]) + 256 * int'(frame_q[p+2]);
        if (n + BASE > (1 << AW)) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++) begin
                w  = w | (32'(frame_q[p+3+4*i+k]) << (8*k));
                cs = cs ^ frame_q[p+3+4*i+k];
            end
            exp_q.push_back({30'(BASE + i), w});
        end
        exp_done = (frame_q[p+3+4*n] == cs);
        exp_err  = !exp_done;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (t >= 10) chk("rx_ready_timeout", 64'(t), 64'd0);
        @(negedge clk);
        if (!bp) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic make_frame(input int n, input bit corrupt, input int noise);
        logic [7:0] b;
        logic [7:0] cs = 8'h00;
        frame_q.delete();
        for (int i = 0; i < noise; i++) begin
            b = 8'($urandom);
            if (b == MAG) b = 8'h00;
            frame_q.push_back(b);
        end
        frame_q.push_back(MAG);
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            cs = cs ^ b;
            frame_q.push_back(b);
        end
        if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
        frame_q.push_back(cs);
    endtask

    task automatic run_frame(input string tag);
        int t = 0;
        build_expect();
        got_q.delete();
        foreach (frame_q[i]) send_byte(frame_q[i]);
        rx_valid = 1'b0;
        while (!(done || error) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_finish_timeout"}, 64'(t < 20), 64'd1);
        repeat (2) @(negedge clk);
        chk({tag, "_write_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
        chk({tag, "_done"}, 64'(done), 64'(exp_done));
        chk({tag, "_error"}, 64'(error), 64'(exp_err));
        chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(!exp_done));
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_rearm_done"}, 64'(done), 64'd0);
        chk({tag, "_rearm_error"}, 64'(error), 64'd0);
        chk({tag, "_rearm_hold"}, 64'(cpu_hold), 64'd1);
        chk({tag, "_rearm_addr"}, 64'(mem_address), 64'(BASE));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd1);
        chk({tag, "_wen"}, 64'(mem_wen), 64'd0);
        chk({tag, "_ren"}, 64'(mem_ren), 64'd0);
        chk({tag, "_addr"}, 64'(mem_address), 64'(BASE));
        chk({tag, "_data"}, 64'(mem_data_in), 64'd0);
        chk({tag, "_bsel"}, 64'(mem_byte_select), 64'd0);
        chk({tag, "_hold"}, 64'(cpu_hold), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        frame_q = '{8'hB0, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                    8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
        run_frame("happy");
        chk("happy_known_count", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            chk("happy_known_w0", 64'(got_q[0]), {2'b00, 30'd0, 32'h0000_0013});
            chk("happy_known_w1", 64'(got_q[1]), {2'b00, 30'd1, 32'h0000_006F});
        end
        chk("happy_known_done", 64'(done), 64'd1);
        do_start("happy");

        frame_q[11] = 8'h00;
        run_frame("bad_csum");
        chk("bad_csum_known_error", 64'(error), 64'd1);
        do_start("bad_csum");
        frame_q[11] = 8'h7C;
        run_frame("after_rearm");
        do_start("after_rearm");

        frame_q = '{8'h55, 8'hAA, 8'hB0, 8'h00, 8'h00, 8'h00};
        run_frame("empty");
        chk("empty_known_done", 64'(done), 64'd1);
        do_start("empty");

        frame_q = '{8'hB0, 8'h01, 8'h08, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        run_frame("oversize");
        chk("oversize_known_error", 64'(error), 64'd1);
        do_start("oversize");

        bp = 1'b1;
        make_frame(5, 1'b0, 0);
        run_frame("backpressure");
        do_start("backpressure");
        make_frame(1 << AW, 1'b0, 0);
        run_frame("full_memory");
        do_start("full_memory");
        bp = 1'b0;

        frame_q = '{8'hB0, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        got_q.delete();
        foreach (frame_q[i]) send_byte(frame_q[i]);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midreset");
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_write_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1)
            chk("midreset_write", 64'(got_q[0]), {2'b00, 30'd0, 32'h4433_2211});
        make_frame(3, 1'b0, 1);
        run_frame("after_reset");
        do_start("after_reset");

        for (int f = 0; f < 12; f++) begin
            bp = 1'($urandom_range(0, 1));
            make_frame($urandom_range(0, 9), ($urandom_range(0, 2) == 0), $urandom_range(0, 3));
            run_frame("random");
            do_start("random");
        end
        bp = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
